// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: default operand width and FSM states.
package serial_adder_pkg;

    localparam int WIDTH_DEFAULT = 4;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/full_adder.sv
// Single-bit combinational full adder used by the serial datapath.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ cin;
    assign co = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: LOAD captures operands, WIDTH ADD cycles ripple LSB-first
// through one full adder, DONE idles a cycle; results register on completion.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_a,
    input  logic [WIDTH-1:0] data_b,
    output logic [WIDTH-1:0] out,
    output logic             cout
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-2:0] psum;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             sum_bit;
    logic             carry_next;

    full_adder u_fa (
        .a   (op_a[0]),
        .b   (op_b[0]),
        .cin (carry),
        .s   (sum_bit),
        .co  (carry_next)
    );

    // psum holds the low WIDTH-1 sum bits; the final bit joins them straight into out.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= LOAD;
            op_a  <= '0;
            op_b  <= '0;
            psum  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            out   <= '0;
            cout  <= 1'b0;
        end else begin
            case (state)
                LOAD: begin
                    op_a  <= data_a;
                    op_b  <= data_b;
                    psum  <= '0;
                    carry <= 1'b0;
                    cnt   <= '0;
                    state <= ADD;
                end
                ADD: begin
                    op_a  <= op_a >> 1;
                    op_b  <= op_b >> 1;
                    psum  <= (WIDTH-1)'({sum_bit, psum} >> 1);
                    carry <= carry_next;
                    cnt   <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        out   <= {sum_bit, psum};
                        cout  <= carry_next;
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= LOAD;
                end
                default: begin
                    state <= LOAD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench: each addition is predicted as plain (WIDTH+1)-bit arithmetic
// and the result is tracked against the fixed WIDTH+2 cycle repetition.
module tb_serial_adder;

    localparam int W = 4;

    logic         clk;
    logic         reset;
    logic [W-1:0] data_a;
    logic [W-1:0] data_b;
    logic [W-1:0] out;
    logic         cout;

    int checks;
    int failures;
    logic [W:0] prev;

    serial_adder #(.WIDTH(W)) dut (
        .clk    (clk),
        .reset  (reset),
        .data_a (data_a),
        .data_b (data_b),
        .out    (out),
        .cout   (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W:0] obs, input logic [W:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed={cout,out}=%b required=%b", tag, obs, exp);
        end
    endtask

    // Called at a negedge just before a LOAD edge; ends at the negedge after DONE.
    task automatic do_add(input string tag,
                          input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] mid_a, input logic [W-1:0] mid_b,
                          input bit rnd_mid);
        logic [W:0] expv;
        expv   = {1'b0, a} + {1'b0, b};
        data_a = a;
        data_b = b;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check({tag, "_hold"}, {cout, out}, prev);
            if (i == 0) begin
                data_a = mid_a;
                data_b = mid_b;
            end else if (rnd_mid) begin
                data_a = W'($urandom);
                data_b = W'($urandom);
            end
        end
        @(negedge clk);
        check({tag, "_result"}, {cout, out}, expv);
        @(negedge clk);
        check({tag, "_done"}, {cout, out}, expv);
        prev = expv;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        prev     = '0;
        reset    = 1'b0;
        data_a   = 4'b1111;
        data_b   = 4'b0000;

        #1;
        check("reset_async", {cout, out}, 5'b0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("reset_hold", {cout, out}, 5'b0);
        end
        reset = 1'b1;

        do_add("a1100_b1101", 4'b1100, 4'b1101, 4'b1100, 4'b1101, 1'b0);
        do_add("a1111_b0001", 4'b1111, 4'b0001, 4'b1111, 4'b0001, 1'b0);
        do_add("a0000_b0000", 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);
        do_add("mid_change", 4'b0011, 4'b0101, 4'b1111, 4'b1111, 1'b0);
        do_add("a1111_b1111", 4'b1111, 4'b1111, 4'b1111, 4'b1111, 1'b0);

        for (int n = 0; n < 12; n++) begin
            logic [W-1:0] ra, rb, ma, mb;
            ra = W'($urandom);
            rb = W'($urandom);
            ma = W'($urandom);
            mb = W'($urandom);
            do_add("random", ra, rb, ma, mb, 1'b1);
        end

        // Abort: LOAD edge, two ADD edges, then reset in the middle of the third ADD cycle.
        data_a = 4'b1010;
        data_b = 4'b0111;
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;
        #1;
        check("abort_async", {cout, out}, 5'b0);
        @(negedge clk);
        check("abort_hold", {cout, out}, 5'b0);
        reset = 1'b1;
        prev  = '0;
        do_add("after_abort", 4'b0110, 4'b0111, 4'b0001, 4'b1000, 1'b1);
        do_add("after_abort2", 4'b1001, 4'b1001, 4'b0000, 4'b0000, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter: WIDTH, default 4, operand/result bit width; all behaviour below is stated for WIDTH=4.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-004 data_a  input  WIDTH  operand A, unsigned.
REQ-005 data_b  input  WIDTH  operand B, unsigned.
REQ-006 out  output  WIDTH  registered sum of last completed addition, low WIDTH bits.
REQ-007 cout  output  1  registered carry-out of last completed addition.

Function
REQ-008 The block SHALL compute data_a + data_b bit-serially, LSB first, using one 1-bit full adder and a 1-bit carry flip-flop.
REQ-009 FSM states SHALL be LOAD, ADD, DONE; only these transitions are legal: LOAD->ADD, ADD->ADD, ADD->DONE, DONE->LOAD.
REQ-010 In LOAD (one cycle), the block SHALL capture data_a and data_b into internal shift registers and clear the carry flip-flop and the bit counter.
REQ-011 In ADD, each cycle SHALL add the current LSBs of both shift registers plus carry, shift the sum bit into a partial-sum register MSB-first (shift right), shift both operand registers right, update carry, and increment the counter.
REQ-012 ADD SHALL last exactly WIDTH cycles; on the edge completing the last ADD step, out SHALL load the full partial sum and cout the final carry, and the FSM SHALL enter DONE.
REQ-013 DONE SHALL last one cycle, then return to LOAD; the block repeats continuously with a period of WIDTH+2 cycles.
REQ-014 out and cout SHALL change only on the completion edge (REQ-012); they hold stable at all other times, including while the next addition is in progress.
REQ-015 Latency: first result valid after the (WIDTH+1)th rising edge following reset deassertion (5th edge for WIDTH=4).
REQ-016 Operands SHALL be sampled only in LOAD; changes on data_a/data_b during ADD/DONE SHALL NOT affect the addition in progress.
REQ-017 Overflow: {cout,out} SHALL equal the exact (WIDTH+1)-bit sum; no saturation.

Reset
REQ-018 While reset=0, the FSM SHALL be in LOAD and out, cout, carry, counter, operand and partial-sum registers SHALL be 0, independent of clk.
REQ-019 Reset assertion mid-ADD SHALL abort the addition immediately; out/cout read 0; after release, operation restarts from LOAD with fresh operands.
REQ-020 The first rising edge after reset deassertion SHALL perform LOAD.

Structure
REQ-021 A shared package serial_adder_pkg SHALL hold the WIDTH default constant and the FSM state enum typedef.
REQ-022 One sub-module full_adder (inputs a, b, cin; outputs s, co, purely combinational) SHALL be instantiated once; counter width is $clog2(WIDTH+1).

Verification
REQ-023 Hold reset=0 for 2 cycles with data_a=1111, data_b=0000 -> out=0000, cout=0 throughout, FSM in LOAD.
REQ-024 Release reset, data_a=1100, data_b=1101 -> after 5th rising edge out=1001, cout=1; stable over the following 6 cycles.
REQ-025 data_a=1111, data_b=0001 -> out=0000, cout=1 (full carry ripple); data_a=0000, data_b=0000 -> out=0000, cout=0.
REQ-026 Load data_a=0011, data_b=0101, then change to 1111/1111 during ADD -> result out=1000, cout=0; next period yields out=1110, cout=1.
REQ-027 Assert reset during 3rd ADD cycle, asynchronously between edges -> out/cout go to 0 at once; after release, first result appears on the 5th edge.
